// File: rtl/zx8x_vram_sequencer.sv
// Video RAM sequencer: walks 32 character cells per scanline (display file code, then
// charset row) and interleaves single CPU writes into the gaps between cells.
module zx8x_vram_sequencer #(
    parameter logic [12:0] CHARSET_BASE = 13'h0000,
    parameter logic [12:0] DFILE_BASE   = 13'h0200,
    parameter int          COLS         = 32,
    parameter int          LINES        = 192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [7:0]  scan_line,
    input  logic        cpu_req,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    output logic        cpu_ack,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_d,
    output logic        ram_we,
    input  logic [7:0]  ram_q,
    output logic [7:0]  pix_byte,
    output logic        pix_valid,
    output logic        busy,
    output logic        line_done,
    output logic        overrun,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHAR_RD  = 3'd1,
        S_CHAR_LAT = 3'd2,
        S_PIX_RD   = 3'd3,
        S_PIX_LAT  = 3'd4,
        S_CPU_WR   = 3'd5
    } state_t;

    // Handshake: cpu_req is held with cpu_addr/cpu_data stable until cpu_ack pulses; the
    // write happens in the cycle before cpu_ack, and req is ignored while cpu_ack is high.

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [2:0]  sub_q, sub_d;
    logic [4:0]  col_q, col_d;
    logic [7:0]  code_q, code_d;
    logic [12:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_d_q, ram_d_d;
    logic        ram_we_q, ram_we_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [7:0]  pix_byte_q, pix_byte_d;
    logic        pix_valid_q, pix_valid_d;
    logic        busy_q, busy_d;
    logic        line_done_q, line_done_d;
    logic        overrun_q, overrun_d;

    logic line_ok;
    logic cpu_go;

    assign line_ok = line_start && (int'(scan_line) < LINES);
    assign cpu_go  = cpu_req && !cpu_ack_q;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        sub_d       = sub_q;
        col_d       = col_q;
        code_d      = code_q;
        ram_addr_d  = ram_addr_q;
        ram_d_d     = ram_d_q;
        ram_we_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        pix_byte_d  = pix_byte_q;
        pix_valid_d = 1'b0;
        busy_d      = busy_q;
        line_done_d = 1'b0;
        overrun_d   = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_go) state_d = S_CPU_WR;
            end
            S_CHAR_RD:  state_d = S_CHAR_LAT;
            S_CHAR_LAT: begin
                code_d  = ram_q;
                state_d = S_PIX_RD;
            end
            S_PIX_RD:   state_d = S_PIX_LAT;
            S_PIX_LAT: begin
                pix_byte_d  = code_q[7] ? ~ram_q : ram_q;
                pix_valid_d = 1'b1;
                if (col_q == 5'(COLS - 1)) begin
                    line_done_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    col_d   = col_q + 5'd1;
                    state_d = cpu_go ? S_CPU_WR : S_CHAR_RD;
                end
            end
            S_CPU_WR: begin
                cpu_ack_d = 1'b1;
                state_d   = busy_q ? S_CHAR_RD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A valid line_start always wins: it restarts from col 0 in any state. A write
        // already in CPU_WR has happened this cycle, so its ack still goes out.
        if (line_ok) begin
            if (busy_q) overrun_d = 1'b1;
            row_d       = scan_line[7:3];
            sub_d       = scan_line[2:0];
            col_d       = 5'd0;
            busy_d      = 1'b1;
            pix_valid_d = 1'b0;
            line_done_d = 1'b0;
            state_d     = S_CHAR_RD;
        end

        // RAM address is registered, so it is set up from the next-state values.
        case (state_d)
            S_CHAR_RD: ram_addr_d = DFILE_BASE + 13'(row_d) * 13'(COLS) + 13'(col_d);
            S_PIX_RD:  ram_addr_d = CHARSET_BASE + {4'b0000, code_d[5:0], sub_d};
            S_CPU_WR: begin
                ram_addr_d = cpu_addr;
                ram_d_d    = cpu_data;
                ram_we_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_q       <= 5'd0;
            sub_q       <= 3'd0;
            col_q       <= 5'd0;
            code_q      <= 8'd0;
            ram_addr_q  <= 13'd0;
            ram_d_q     <= 8'd0;
            ram_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            pix_byte_q  <= 8'd0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            sub_q       <= sub_d;
            col_q       <= col_d;
            code_q      <= code_d;
            ram_addr_q  <= ram_addr_d;
            ram_d_q     <= ram_d_d;
            ram_we_q    <= ram_we_d;
            cpu_ack_q   <= cpu_ack_d;
            pix_byte_q  <= pix_byte_d;
            pix_valid_q <= pix_valid_d;
            busy_q      <= busy_d;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign ram_addr  = ram_addr_q;
    assign ram_d     = ram_d_q;
    assign ram_we    = ram_we_q;
    assign pix_byte  = pix_byte_q;
    assign pix_valid = pix_valid_q;
    assign busy      = busy_q;
    assign line_done = line_done_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_zx8x_vram_sequencer.sv
// Directed bench for zx8x_vram_sequencer with a registered-read RAM model and an
// expected-pixel queue per scanline.
module tb_zx8x_vram_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [7:0]  scan_line;
    logic        cpu_req;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ack;
    logic [12:0] ram_addr;
    logic [7:0]  ram_d;
    logic        ram_we;
    logic [7:0]  ram_q;
    logic [7:0]  pix_byte;
    logic        pix_valid;
    logic        busy;
    logic        line_done;
    logic        overrun;
    logic [2:0]  dbg_state;

    // clock / reset
    always #5 clk = ~clk;

    zx8x_vram_sequencer dut (
        .clk(clk), .reset(reset), .line_start(line_start), .scan_line(scan_line),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
        .pix_byte(pix_byte), .pix_valid(pix_valid), .busy(busy), .line_done(line_done),
        .overrun(overrun), .dbg_state(dbg_state)
    );

    // RAM model: charset bytes are addr^5A, display file bytes are (index*7)&FF.
    logic [7:0]  mem [0:8191];
    logic        init_mem;
    logic        poke_en;
    logic [12:0] poke_addr;
    logic [7:0]  poke_data;

    function automatic logic [7:0] init_val(input int a);
        logic [12:0] aa;
        int          v;
        aa = 13'(a);
        if (a == 43) return 8'h3C;
        if (a == 13'h0240) return 8'h05;
        if (a < 512) return aa[7:0] ^ 8'h5A;
        if (a < 512 + 768) begin
            v = (a - 512) * 7;
            return 8'(v);
        end
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int a = 0; a < 8192; a++) mem[a] <= init_val(a);
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_d;
        end
        ram_q <= mem[ram_addr];
    end

    // scoreboard
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_pix [0:31];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_pix(input logic [7:0] sl, input int col);
        logic [12:0] a;
        logic [7:0]  code;
        logic [7:0]  b;
        a    = 13'h0200 + 13'(sl[7:3]) * 13'd32 + 13'(col);
        code = mem[a];
        b    = mem[{4'b0000, code[5:0], sl[2:0]}];
        return code[7] ? ~b : b;
    endfunction

    // driver tasks (called and returning on a negedge)
    task automatic pulse_line(input logic [7:0] sl);
        line_start = 1'b1;
        scan_line  = sl;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic poke(input logic [12:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic run_line(input logic [7:0] sl, input bit use_cpu, input int exp_busy);
        int cyc, busy_cnt, first, npix, writes, acks, w;
        logic prev_we;
        exp_q.delete();
        for (int c = 0; c < 32; c++) exp_q.push_back(ref_pix(sl, c));
        busy_cnt = 0; first = 0; npix = 0; writes = 0; acks = 0; prev_we = 1'b0;
        if (use_cpu) begin
            cpu_req = 1'b1; cpu_addr = 13'h1000; cpu_data = 8'h11;
        end
        pulse_line(sl);
        cyc = 1;
        while (cyc < 400) begin
            if (busy) busy_cnt++;
            if (pix_valid) begin
                if (npix == 0) first = cyc;
                if (exp_q.size() > 0) check("pix", pix_byte, exp_q.pop_front());
                if (npix < 32) got_pix[npix] = pix_byte;
                npix++;
                check("line_done", line_done, (npix == 32));
            end else if (line_done) begin
                check("line_done_stray", line_done, 1'b0);
            end
            if (ram_we) begin
                check("we_single", prev_we, 1'b0);
                check("wr_addr", ram_addr, cpu_addr);
                check("wr_data", ram_d, cpu_data);
                writes++;
            end
            prev_we = ram_we;
            if (cpu_ack) begin
                acks++;
                cpu_addr = cpu_addr + 13'd1;
                cpu_data = cpu_data + 8'd3;
            end
            if (cyc > 1 && !busy) break;
            @(negedge clk);
            cyc++;
        end
        check("line_timeout", (cyc < 400), 1'b1);
        check("first_latency", first, 5);
        check("pix_count", npix, 32);
        check("busy_cycles", busy_cnt, exp_busy);
        check("exp_q_empty", exp_q.size(), 0);
        if (use_cpu) begin
            // The last cell has no gap, so 31 writes land inside the line.
            check("line_writes", writes, 31);
            check("line_acks", acks, 31);
            w = 0;
            while (!cpu_ack && w < 8) begin
                @(negedge clk);
                w++;
                if (ram_we) writes++;
            end
            check("idle_ack", cpu_ack, 1'b1);
            check("total_writes", writes, 32);
            cpu_req = 1'b0;
            @(negedge clk);
            check("ack_single", cpu_ack, 1'b0);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c, n2;
        bit saw;
        reset = 1'b1; init_mem = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        line_start = 1'b0; scan_line = '0; cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
        @(negedge clk);
        init_mem = 1'b0;
        @(negedge clk);
        check("rst_state", dbg_state, 3'd0);
        check("rst_pix_byte", pix_byte, 8'h00);
        check("rst_pix_valid", pix_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_ram_addr", ram_addr, 13'h0000);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_cpu_ack", cpu_ack, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // glyph 5 row 3 via display file code 05, then inverse code 85
        run_line(8'd19, 1'b0, 128);
        check("glyph_plain", got_pix[0], 8'h3C);
        poke(13'h0240, 8'h85);
        run_line(8'd19, 1'b0, 128);
        check("glyph_inverse", got_pix[0], 8'hC3);

        // CPU write from IDLE
        cpu_req = 1'b1; cpu_addr = 13'h0210; cpu_data = 8'hAA;
        @(negedge clk);
        check("idle_we", ram_we, 1'b1);
        check("idle_wr_addr", ram_addr, 13'h0210);
        check("idle_wr_data", ram_d, 8'hAA);
        check("idle_ack_early", cpu_ack, 1'b0);
        @(negedge clk);
        check("idle_we_drop", ram_we, 1'b0);
        check("idle_ack", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        @(negedge clk);
        check("idle_ack_drop", cpu_ack, 1'b0);
        check("idle_no_rewrite", ram_we, 1'b0);
        // readback through the video path: code AA -> glyph 2A row 3 = 09, inverted
        run_line(8'd3, 1'b0, 128);
        check("readback_pix", got_pix[16], 8'hF6);

        // CPU held through a whole line
        run_line(8'd100, 1'b1, 159);

        // line_start at col 10 aborts and restarts
        pulse_line(8'd19);
        c = 1; n2 = 0;
        while (c < 100) begin
            if (pix_valid) n2++;
            if (n2 == 10) break;
            @(negedge clk);
            c++;
        end
        check("ovr_reach_col10", n2, 10);
        check("ovr_before", overrun, 1'b0);
        pulse_line(8'd42);
        c = 1;
        while (!pix_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("ovr_latency", c, 5);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_first_pix", pix_byte, 8'h58);
        n2 = 1;
        do begin
            @(negedge clk);
            c++;
            if (pix_valid) n2++;
        end while (busy && c < 300);
        check("ovr_new_line_pix", n2, 32);
        repeat (2) @(negedge clk);

        // out-of-range scanline ignored
        pulse_line(8'd192);
        saw = 1'b0;
        repeat (8) begin
            if (busy || pix_valid) saw = 1'b1;
            @(negedge clk);
        end
        check("ignore_192", saw, 1'b0);
        check("ovr_sticky", overrun, 1'b1);

        // asynchronous reset mid-line
        pulse_line(8'd19);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_state", dbg_state, 3'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_pix_byte", pix_byte, 8'h00);
        check("mid_rst_ram_addr", ram_addr, 13'h0000);
        check("mid_rst_overrun", overrun, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pix_valid || busy) saw = 1'b1;
        end
        check("post_rst_quiet", saw, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
